// File: rtl/operation_timer_pkg.sv
// Shared types and field widths for the operation timer and its upstream mode FSM.
package operation_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned PWM_W   = 3;
   localparam int unsigned TIME_W  = 4;
   localparam int unsigned POWER_W = 3;

endpackage

// File: rtl/operation_timer_tick_divider.sv
// Time-unit prescaler: emits a one-cycle tick each TICKS_PER_UNIT enabled cycles.
module tick_divider #(
   parameter int unsigned TICKS_PER_UNIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic enable,
   output logic tick
);

   localparam logic [7:0] RELOAD = 8'(TICKS_PER_UNIT - 1);

   logic [7:0] count_q, count_d;

   assign tick = enable && (count_q == '0);

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = RELOAD;
      end else if (enable) begin
         count_d = (count_q == '0) ? RELOAD : count_q - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

endmodule

// File: rtl/operation_timer.sv
// Runs one timed operation: latches power/time on start, counts down in
// prescaled units and drives a power-proportional PWM heater enable.
module operation_timer
   import operation_timer_pkg::*;
#(
   parameter int unsigned TICKS_PER_UNIT = 4,
   parameter int unsigned PWM_PERIOD     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [POWER_W-1:0] U,
   input  logic [TIME_W-1:0]  R,
   output logic               heater,
   output logic               busy,
   output logic               done,
   output logic [TIME_W-1:0]  remaining
);

   localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_PERIOD - 1);

   state_t             state_q, state_d;
   logic [POWER_W-1:0] u_lat_q, u_lat_d;
   logic [TIME_W-1:0]  rem_q,   rem_d;
   logic [PWM_W-1:0]   pwm_q,   pwm_d;
   logic               presc_load;
   logic               tick;

   tick_divider #(
      .TICKS_PER_UNIT(TICKS_PER_UNIT)
   ) u_tick_divider (
      .clk    (clk),
      .rst    (rst),
      .load   (presc_load),
      .enable (state_q == RUN),
      .tick   (tick)
   );

   always_comb begin
      state_d    = state_q;
      u_lat_d    = u_lat_q;
      rem_d      = rem_q;
      pwm_d      = pwm_q;
      presc_load = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && !stop && (R != '0)) begin
               state_d    = RUN;
               u_lat_d    = U;
               rem_d      = R;
               pwm_d      = '0;
               presc_load = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               rem_d   = '0;
            end else begin
               pwm_d = (pwm_q == PWM_LAST) ? '0 : pwm_q + PWM_W'(1);
               // The final unit expires straight into DONE; R=0 is never accepted so no underflow.
               if (tick) begin
                  rem_d = rem_q - TIME_W'(1);
                  if (rem_q == TIME_W'(1)) state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         u_lat_q <= '0;
         rem_q   <= '0;
         pwm_q   <= '0;
      end else begin
         state_q <= state_d;
         u_lat_q <= u_lat_d;
         rem_q   <= rem_d;
         pwm_q   <= pwm_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign heater    = (state_q == RUN) && (pwm_q < u_lat_q);
   assign remaining = rem_q;

endmodule

// File: doc/operation_timer.md
Name: operation_timer

Overview:
- Executes one cooking/operation cycle from the power level and time setting produced by the mode-control FSM.
- On a start request it latches the power (3-bit) and time (4-bit) values, then counts the time down in prescaled units.
- While running it drives a PWM heater enable whose duty cycle follows the latched power level.
- It raises a one-cycle done pulse at expiry. It sits directly downstream of the mode FSM and feeds the actuator and display logic.

Parameters:
- TICKS_PER_UNIT, 4, clock cycles per time unit. Legal range is 2..255; the prescaler is 8 bits wide.
- PWM_PERIOD, 8, heater PWM period in cycles. It is fixed at 8 so the 3-bit power value maps to duty p/8.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request to begin an operation; level-sampled, honoured only in IDLE
- stop  in  1  abort request; honoured in any state
- U  in  3  power level from the mode FSM; 0 = off, 7 = 7/8 duty
- R  in  4  time setting from the mode FSM, in units; 0 = invalid
- heater  out  1  PWM heater enable
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on normal completion
- remaining  out  4  time units left, including the current unit

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, heater=0, busy=0, done=0, remaining=0. The prescaler, PWM counter and latched U are cleared. Reset overrides start and stop, including when asserted mid-RUN.
- State encoding is 2 bits: IDLE, RUN, DONE.
- IDLE:
  - start=1, stop=0, R!=0 → RUN at the next edge.
  - On that edge: latch u_lat<=U, remaining<=R, presc<=TICKS_PER_UNIT-1, pwm<=0.
  - start=1 with R=0 → ignored; stay in IDLE.
  - start=1 with stop=1 → stop wins; stay in IDLE.
- RUN, each cycle:
  - pwm<=pwm+1, wrapping 7→0.
  - If presc!=0: presc<=presc-1.
  - If presc==0: presc<=TICKS_PER_UNIT-1 and remaining<=remaining-1.
  - If presc==0 and remaining==1: go to DONE with remaining<=0.
  - Total RUN duration is exactly R*TICKS_PER_UNIT cycles.
- RUN with stop=1 → IDLE at the next edge. remaining<=0, no done pulse, heater low from that edge on.
- RUN with start=1 → ignored. U and R changes during RUN are ignored; only the latched values are used.
- DONE: done=1 for exactly one cycle, then unconditionally IDLE. start during DONE is ignored. stop during DONE goes to IDLE with no other effect; done is still 1 for that cycle.
- Output decoding:
  - busy = (state==RUN).
  - heater = (state==RUN) && (pwm < u_lat).
  - All outputs decode from registers only; there is no combinational path from any input to any output.
- Heater duty:
  - u_lat=0 → heater never high.
  - u_lat=7 → heater high 7 of every 8 RUN cycles.
  - The PWM phase restarts at 0 on every start.
- Widths: remaining and its decrement are 4-bit unsigned; the decrement can never underflow because R=0 is rejected. pwm is 3-bit and wraps naturally.

Decomposition:
- Shared package holds the state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the PWM_W=3 and TIME_W=4 constants, and the power/time field widths shared with the mode FSM.
- One sub-module: tick_divider (prescaler).
  - Inputs: load, enable.
  - Output: a one-cycle tick when the count reaches 0, then it reloads TICKS_PER_UNIT-1.
  - The PWM counter and the FSM stay in operation_timer.

Test Plan (TICKS_PER_UNIT=4):
- Nominal run: rst, then start=1 for 1 cycle with R=3, U=2 → busy high for 12 cycles, remaining steps 3,2,1 every 4 cycles. done=1 on the cycle after the last busy cycle, then idle. heater high in 4 of the 12 cycles (pwm=0,1 twice).
- Power extremes: U=0, R=2 → heater stays 0 for all 8 busy cycles. U=7, R=2 → heater high 7 cycles, low only when pwm=7.
- Abort: R=5, stop=1 in the 6th RUN cycle → busy drops on the next edge, remaining=0, done never asserts, heater=0.
- Illegal and conflicting starts:
  - R=0 with start → stays idle, busy=0.
  - start together with stop in IDLE → stays idle.
  - start pulsed again mid-RUN with R=9, U=5 → timing and duty continue using the original latched values.
- Reset mid-operation: rst=1 in the middle of RUN → all outputs 0 next cycle. A subsequent start with R=1 runs for exactly 4 cycles and gives one done pulse.
- Back-to-back: start held high continuously with R=1 → pattern of 4 busy cycles, 1 done cycle, 1 idle cycle (start accepted), repeating; done pulses are 6 cycles apart.
